// File: rtl/conn_header_streamer.sv
// Scans the connection-record RAM and streams one Ethernet+IPv4+TCP header
// (14 big-endian words, IPv4 checksum filled in) for every record with its valid bit set.
//
// state      | meaning
// IDLE       | waiting for start
// RD_VALID   | R0 address presented; held while the writer owns the RAM
// CHECK      | R0 on ram_q, test valid bit
// FETCH      | R1..R8 addressed back to back, each captured one cycle later
// CSUM1      | 20-bit sum of the IP header halfwords
// CSUM2      | fold carries, invert, load word 0
// EMIT       | stream words 0..13 on the valid/ready handshake
// NEXT       | advance record index or finish the pass
module conn_header_streamer #(
    parameter int NUM_CONN  = 8,
    parameter int REC_WORDS = 9,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int IP_TTL    = 64,
    localparam int CONN_W   = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ram_busy,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_q,
    output logic [31:0]       hdr_data,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic              hdr_last,
    output logic [CONN_W-1:0] hdr_conn,
    output logic              scan_busy,
    output logic              scan_done
);

    localparam logic [7:0] TTL8 = 8'(IP_TTL);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_VALID, S_CHECK, S_FETCH, S_CSUM1, S_CSUM2, S_EMIT, S_NEXT
    } state_t;

    state_t            state;
    logic [CONN_W-1:0] idx;
    logic [3:0]        fcnt;
    logic [3:0]        widx;
    logic [15:0]       window;
    logic [5:0]        flags;
    logic [31:0]       seq, ack, ip_src, ip_dst;
    logic [47:0]       mac_src, mac_dst;
    logic [15:0]       src_port, dst_port;
    logic [15:0]       ip_id, ip_csum;
    logic [19:0]       sum20;
    logic [19:0]       hsum;
    logic [16:0]       fold1;
    logic [15:0]       fold2;
    logic              last_conn;

    assign last_conn = (idx == CONN_W'(NUM_CONN - 1));

    function automatic logic [ADDR_W-1:0] rec_addr(input logic [CONN_W-1:0] i,
                                                    input logic [3:0] w);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(i) * ADDR_W'(REC_WORDS) + ADDR_W'(w);
    endfunction

    function automatic logic [31:0] hdr_word(input logic [3:0] n);
        logic [31:0] w;
        case (n)
            4'd0:    w = mac_dst[47:16];
            4'd1:    w = {mac_dst[15:0], mac_src[47:32]};
            4'd2:    w = mac_src[31:0];
            4'd3:    w = {16'h0800, 8'h45, 8'h00};
            4'd4:    w = {16'd40, ip_id};
            4'd5:    w = {16'h4000, TTL8, 8'h06};
            4'd6:    w = {ip_csum, ip_src[31:16]};
            4'd7:    w = {ip_src[15:0], ip_dst[31:16]};
            4'd8:    w = {ip_dst[15:0], src_port};
            4'd9:    w = {dst_port, seq[31:16]};
            4'd10:   w = {seq[15:0], ack[31:16]};
            4'd11:   w = {ack[15:0], 8'h50, 2'b00, flags};
            4'd12:   w = {window, 16'h0000};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Ten IP halfwords with the checksum field taken as zero; two folds absorb all carries.
    always_comb begin
        hsum  = 20'h04500 + 20'h00028 + {4'h0, ip_id} + 20'h04000 + {4'h0, TTL8, 8'h06}
              + {4'h0, ip_src[31:16]} + {4'h0, ip_src[15:0]}
              + {4'h0, ip_dst[31:16]} + {4'h0, ip_dst[15:0]};
        fold1 = {1'b0, sum20[15:0]} + {13'd0, sum20[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            fcnt      <= '0;
            widx      <= '0;
            window    <= '0;
            flags     <= '0;
            seq       <= '0;
            ack       <= '0;
            ip_src    <= '0;
            ip_dst    <= '0;
            mac_src   <= '0;
            mac_dst   <= '0;
            src_port  <= '0;
            dst_port  <= '0;
            ip_id     <= '0;
            ip_csum   <= '0;
            sum20     <= '0;
            ram_addr  <= '0;
            hdr_data  <= '0;
            hdr_valid <= 1'b0;
            hdr_last  <= 1'b0;
            hdr_conn  <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        scan_busy <= 1'b1;
                        idx       <= '0;
                        ram_addr  <= rec_addr('0, 4'd0);
                        state     <= S_RD_VALID;
                    end
                end
                S_RD_VALID: begin
                    if (!ram_busy) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (ram_busy) begin
                        state <= S_RD_VALID;
                    end else if (ram_q[0]) begin
                        window   <= ram_q[31:16];
                        flags    <= ram_q[13:8];
                        fcnt     <= '0;
                        ram_addr <= rec_addr(idx, 4'd1);
                        state    <= S_FETCH;
                    end else begin
                        scan_done <= last_conn;
                        state     <= S_NEXT;
                    end
                end
                S_FETCH: begin
                    // Any busy cycle may have corrupted a word already in flight: redo the record.
                    if (ram_busy) begin
                        ram_addr <= rec_addr(idx, 4'd0);
                        state    <= S_RD_VALID;
                    end else begin
                        case (fcnt)
                            4'd1: seq      <= ram_q;
                            4'd2: ack      <= ram_q;
                            4'd3: ip_src   <= ram_q;
                            4'd4: ip_dst   <= ram_q;
                            4'd5: mac_src[47:16] <= ram_q;
                            4'd6: begin
                                mac_src[15:0]  <= ram_q[31:16];
                                mac_dst[47:32] <= ram_q[15:0];
                            end
                            4'd7: mac_dst[31:0] <= ram_q;
                            4'd8: begin
                                src_port <= ram_q[31:16];
                                dst_port <= ram_q[15:0];
                            end
                            default: ;
                        endcase
                        if (fcnt < 4'd7) ram_addr <= rec_addr(idx, fcnt + 4'd2);
                        fcnt <= fcnt + 4'd1;
                        if (fcnt == 4'd8) state <= S_CSUM1;
                    end
                end
                S_CSUM1: begin
                    sum20 <= hsum;
                    state <= S_CSUM2;
                end
                S_CSUM2: begin
                    ip_csum   <= ~fold2;
                    widx      <= '0;
                    hdr_data  <= hdr_word(4'd0);
                    hdr_valid <= 1'b1;
                    hdr_last  <= 1'b0;
                    hdr_conn  <= idx;
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (hdr_ready) begin
                        if (widx == 4'd13) begin
                            hdr_valid <= 1'b0;
                            hdr_last  <= 1'b0;
                            ip_id     <= ip_id + 16'd1;
                            scan_done <= last_conn;
                            state     <= S_NEXT;
                        end else begin
                            widx     <= widx + 4'd1;
                            hdr_data <= hdr_word(widx + 4'd1);
                            hdr_last <= (widx == 4'd12);
                        end
                    end
                end
                S_NEXT: begin
                    if (last_conn) begin
                        scan_busy <= 1'b0;
                        idx       <= '0;
                        state     <= S_IDLE;
                    end else begin
                        idx      <= idx + 1'b1;
                        ram_addr <= rec_addr(idx + 1'b1, 4'd0);
                        state    <= S_RD_VALID;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conn_header_streamer.sv
// Bench for conn_header_streamer: RAM model, byte-level header reference model,
// random records and random sink back-pressure.
module tb_conn_header_streamer;
    localparam int NC = 4;
    localparam int RW = 9;
    localparam int AW = 9;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ram_busy = 1'b0;
    logic          hdr_ready = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_q;
    logic [31:0]   hdr_data;
    logic          hdr_valid, hdr_last, scan_busy, scan_done;
    logic [CW-1:0] hdr_conn;

    always #5 clk = ~clk;

    conn_header_streamer #(.NUM_CONN(NC), .REC_WORDS(RW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .ram_busy(ram_busy),
        .ram_addr(ram_addr), .ram_q(ram_q), .hdr_data(hdr_data), .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready), .hdr_last(hdr_last), .hdr_conn(hdr_conn),
        .scan_busy(scan_busy), .scan_done(scan_done)
    );

    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) ram_q <= mem[ram_addr];

    int vectors = 0;
    int miscompares = 0;

    // Monitor: records every transfer, counts scan_done pulses and stall-stability violations.
    logic [31:0]   got_data[$];
    logic [CW-1:0] got_conn[$];
    logic          got_last[$];
    int            done_cnt = 0;
    int            stab_err = 0;
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_data = '0;
    logic          prev_last = 1'b0;
    logic [CW-1:0] prev_conn = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!hdr_valid || hdr_data !== prev_data ||
                               hdr_last !== prev_last || hdr_conn !== prev_conn))
                stab_err <= stab_err + 1;
            if (hdr_valid && hdr_ready) begin
                got_data.push_back(hdr_data);
                got_conn.push_back(hdr_conn);
                got_last.push_back(hdr_last);
            end
            if (scan_done) done_cnt <= done_cnt + 1;
            prev_stall <= hdr_valid && !hdr_ready;
            prev_data  <= hdr_data;
            prev_last  <= hdr_last;
            prev_conn  <= hdr_conn;
        end
    end

    logic [31:0]   exp_data[$];
    logic [CW-1:0] exp_conn[$];
    logic          exp_last[$];
    logic [15:0]   model_ip_id = '0;

    // Reference: lay the header out byte by byte, checksum with a fold loop, then pack words.
    task automatic model_pass();
        logic [7:0]  b [56];
        logic [31:0] r [9];
        logic [47:0] ms, md;
        logic [15:0] cs;
        int          sum;
        exp_data.delete(); exp_conn.delete(); exp_last.delete();
        for (int c = 0; c < NC; c++) begin
            for (int w = 0; w < 9; w++) r[w] = mem[c*RW + w];
            if (r[0][0]) begin
                ms = {r[5], r[6][31:16]};
                md = {r[6][15:0], r[7]};
                for (int i = 0; i < 56; i++) b[i] = 8'h00;
                for (int i = 0; i < 6; i++) begin
                    b[i]   = md[47-8*i -: 8];
                    b[6+i] = ms[47-8*i -: 8];
                end
                b[12] = 8'h08; b[14] = 8'h45; b[17] = 8'd40;
                b[18] = model_ip_id[15:8]; b[19] = model_ip_id[7:0];
                b[20] = 8'h40; b[22] = 8'd64; b[23] = 8'd6;
                for (int i = 0; i < 4; i++) begin
                    b[26+i] = r[3][31-8*i -: 8];
                    b[30+i] = r[4][31-8*i -: 8];
                    b[34+i] = r[8][31-8*i -: 8];
                    b[38+i] = r[1][31-8*i -: 8];
                    b[42+i] = r[2][31-8*i -: 8];
                end
                b[46] = 8'h50; b[47] = {2'b00, r[0][13:8]};
                b[48] = r[0][31:24]; b[49] = r[0][23:16];
                sum = 0;
                for (int i = 14; i < 34; i += 2) sum += {b[i], b[i+1]};
                while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
                cs = ~sum[15:0];
                b[24] = cs[15:8]; b[25] = cs[7:0];
                for (int w = 0; w < 14; w++) begin
                    exp_data.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
                    exp_conn.push_back(CW'(c));
                    exp_last.push_back(w == 13);
                end
                model_ip_id++;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 32'h0;
    endtask

    task automatic load_rec(input int c, input bit v);
        logic [31:0] r;
        r = $urandom();
        mem[c*RW] = {r[31:16], 2'b00, r[5:0], 7'b0, v};
        for (int w = 1; w < 9; w++) mem[c*RW + w] = $urandom();
    endtask

    task automatic start_pass();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit rnd, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            hdr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
            if (scan_done) begin ok = 1'b1; break; end
        end
        hdr_ready = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        vectors++; if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL reset hdr_valid: got %b want 0", hdr_valid); end
        vectors++; if (hdr_data !== 32'h0) begin miscompares++; $display("FAIL reset hdr_data: got %h want 0", hdr_data); end
        vectors++; if (hdr_last !== 1'b0) begin miscompares++; $display("FAIL reset hdr_last: got %b want 0", hdr_last); end
        vectors++; if (hdr_conn !== '0) begin miscompares++; $display("FAIL reset hdr_conn: got %0d want 0", hdr_conn); end
        vectors++; if (scan_busy !== 1'b0) begin miscompares++; $display("FAIL reset scan_busy: got %b want 0", scan_busy); end
        vectors++; if (scan_done !== 1'b0) begin miscompares++; $display("FAIL reset scan_done: got %b want 0", scan_done); end
        vectors++; if (ram_addr !== '0) begin miscompares++; $display("FAIL reset ram_addr: got %0d want 0", ram_addr); end
        reset = 1'b0;
        model_ip_id = '0;
        step(2);
    endtask

    task automatic test_known_record();
        int gb, db, n;
        bit ok;
        logic [31:0] w [14];
        clear_mem();
        mem[0] = {16'hFFFF, 2'b00, 6'h12, 7'b0, 1'b1};
        mem[1] = 32'h11223344; mem[2] = 32'h55667788;
        mem[3] = 32'hC0A80001; mem[4] = 32'hC0A800C7;
        mem[5] = $urandom(); mem[6] = $urandom(); mem[7] = $urandom();
        mem[8] = 32'h1F900050;
        gb = got_data.size(); db = done_cnt;
        start_pass();
        n = 1;
        while (!hdr_valid && n < 40) begin step(1); n++; end
        vectors++; if (n != 14) begin miscompares++; $display("FAIL latency: first hdr_valid at cycle %0d want 14", n); end
        run_until_done(1'b0, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL known pass timeout: got no scan_done want scan_done"); end
        model_pass();
        vectors++; if (got_data.size() - gb != exp_data.size()) begin miscompares++; $display("FAIL known word count: got %0d want %0d", got_data.size() - gb, exp_data.size()); end
        for (int i = 0; i < exp_data.size() && gb + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gb+i] !== exp_data[i] || got_conn[gb+i] !== exp_conn[i] || got_last[gb+i] !== exp_last[i]) begin
                miscompares++; $display("FAIL known word %0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[gb+i], got_conn[gb+i], got_last[gb+i], exp_data[i], exp_conn[i], exp_last[i]);
            end
        end
        for (int i = 0; i < 14; i++) w[i] = (gb + i < got_data.size()) ? got_data[gb+i] : 32'hXXXXXXXX;
        vectors++; if (w[3] !== 32'h08004500) begin miscompares++; $display("FAIL W3: got %h want 08004500", w[3]); end
        vectors++; if (w[4] !== 32'h00280000) begin miscompares++; $display("FAIL W4: got %h want 00280000", w[4]); end
        vectors++; if (w[6][31:16] !== 16'hB8B7) begin miscompares++; $display("FAIL ip_csum: got %h want B8B7", w[6][31:16]); end
        vectors++; if (w[8][15:0] !== 16'h1F90) begin miscompares++; $display("FAIL W8 port: got %h want 1F90", w[8][15:0]); end
        vectors++; if (w[9] !== 32'h00501122) begin miscompares++; $display("FAIL W9: got %h want 00501122", w[9]); end
        vectors++; if (w[10] !== 32'h33445566) begin miscompares++; $display("FAIL W10: got %h want 33445566", w[10]); end
        vectors++; if (w[11] !== 32'h77885012) begin miscompares++; $display("FAIL W11: got %h want 77885012", w[11]); end
        vectors++; if (w[12] !== 32'hFFFF0000) begin miscompares++; $display("FAIL W12: got %h want FFFF0000", w[12]); end
        vectors++; if (done_cnt - db != 1) begin miscompares++; $display("FAIL known scan_done count: got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_single_valid();
        int gb, db;
        bit ok;
        clear_mem();
        for (int c = 0; c < NC; c++) load_rec(c, c == 2);
        gb = got_data.size(); db = done_cnt;
        start_pass();
        step(3);
        start_pass();
        run_until_done(1'b0, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single pass timeout: got no scan_done want scan_done"); end
        step(30);
        model_pass();
        vectors++; if (got_data.size() - gb != 14) begin miscompares++; $display("FAIL single word count: got %0d want 14", got_data.size() - gb); end
        for (int i = 0; i < exp_data.size() && gb + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gb+i] !== exp_data[i] || got_conn[gb+i] !== exp_conn[i] || got_last[gb+i] !== exp_last[i]) begin
                miscompares++; $display("FAIL single word %0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[gb+i], got_conn[gb+i], got_last[gb+i], exp_data[i], exp_conn[i], exp_last[i]);
            end
        end
        vectors++; if (done_cnt - db != 1) begin miscompares++; $display("FAIL single scan_done count: got %0d want 1", done_cnt - db); end
        vectors++; if (scan_busy !== 1'b0) begin miscompares++; $display("FAIL dropped start: scan_busy got %b want 0", scan_busy); end
    endtask

    task automatic test_random_ready();
        int gb, db, sb;
        bit ok;
        for (int p = 0; p < 3; p++) begin
            clear_mem();
            for (int c = 0; c < NC; c++) load_rec(c, 1'($urandom_range(0, 1)));
            load_rec($urandom_range(0, NC-1), 1'b1);
            gb = got_data.size(); db = done_cnt; sb = stab_err;
            start_pass();
            run_until_done(1'b1, 2000, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL random pass %0d timeout: got no scan_done want scan_done", p); end
            model_pass();
            vectors++; if (got_data.size() - gb != exp_data.size()) begin miscompares++; $display("FAIL random word count: got %0d want %0d", got_data.size() - gb, exp_data.size()); end
            for (int i = 0; i < exp_data.size() && gb + i < got_data.size(); i++) begin
                vectors++;
                if (got_data[gb+i] !== exp_data[i] || got_conn[gb+i] !== exp_conn[i] || got_last[gb+i] !== exp_last[i]) begin
                    miscompares++; $display("FAIL random word %0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[gb+i], got_conn[gb+i], got_last[gb+i], exp_data[i], exp_conn[i], exp_last[i]);
                end
            end
            vectors++; if (stab_err - sb != 0) begin miscompares++; $display("FAIL stall stability: got %0d violations want 0", stab_err - sb); end
            vectors++; if (done_cnt - db != 1) begin miscompares++; $display("FAIL random scan_done count: got %0d want 1", done_cnt - db); end
        end
    endtask

    task automatic test_ram_busy();
        int gb, n;
        bit ok;
        clear_mem();
        load_rec(0, 1'b1);
        gb = got_data.size();
        start_pass();
        n = 0;
        while (ram_addr !== AW'(5) && n < 50) begin step(1); n++; end
        vectors++; if (ram_addr !== AW'(5)) begin miscompares++; $display("FAIL busy setup: ram_addr got %0d want 5", ram_addr); end
        ram_busy = 1'b1;
        load_rec(0, 1'b1);
        step(3);
        ram_busy = 1'b0;
        run_until_done(1'b0, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL busy pass timeout: got no scan_done want scan_done"); end
        model_pass();
        vectors++; if (got_data.size() - gb != exp_data.size()) begin miscompares++; $display("FAIL busy word count: got %0d want %0d", got_data.size() - gb, exp_data.size()); end
        for (int i = 0; i < exp_data.size() && gb + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gb+i] !== exp_data[i] || got_conn[gb+i] !== exp_conn[i] || got_last[gb+i] !== exp_last[i]) begin
                miscompares++; $display("FAIL busy word %0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[gb+i], got_conn[gb+i], got_last[gb+i], exp_data[i], exp_conn[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int gb, n;
        bit ok;
        clear_mem();
        load_rec(0, 1'b1);
        load_rec(1, 1'b1);
        gb = got_data.size();
        start_pass();
        n = 0;
        while (!(hdr_valid && got_data.size() - gb == 7) && n < 100) begin
            hdr_ready = 1'b1; step(1); n++;
        end
        vectors++; if (got_data.size() - gb != 7) begin miscompares++; $display("FAIL midstream setup: got %0d words want 7", got_data.size() - gb); end
        reset = 1'b1; hdr_ready = 1'b0;
        step(1);
        vectors++; if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL midstream reset hdr_valid: got %b want 0", hdr_valid); end
        vectors++; if (scan_busy !== 1'b0) begin miscompares++; $display("FAIL midstream reset scan_busy: got %b want 0", scan_busy); end
        reset = 1'b0;
        model_ip_id = '0;
        step(2);
        gb = got_data.size();
        start_pass();
        run_until_done(1'b0, 300, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rescan timeout: got no scan_done want scan_done"); end
        model_pass();
        vectors++; if (got_data.size() - gb != exp_data.size()) begin miscompares++; $display("FAIL rescan word count: got %0d want %0d", got_data.size() - gb, exp_data.size()); end
        for (int i = 0; i < exp_data.size() && gb + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gb+i] !== exp_data[i] || got_conn[gb+i] !== exp_conn[i] || got_last[gb+i] !== exp_last[i]) begin
                miscompares++; $display("FAIL rescan word %0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[gb+i], got_conn[gb+i], got_last[gb+i], exp_data[i], exp_conn[i], exp_last[i]);
            end
        end
        if (got_data.size() - gb >= 5) begin
            vectors++; if (got_data[gb+4][15:0] !== 16'h0000) begin miscompares++; $display("FAIL rescan ip_id: got %h want 0000", got_data[gb+4][15:0]); end
            vectors++; if (got_conn[gb] !== '0) begin miscompares++; $display("FAIL rescan first conn: got %0d want 0", got_conn[gb]); end
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_known_record();
        test_single_valid();
        test_random_ready();
        test_ram_busy();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
